// File: rtl/mcs4_bus_master.sv
// MCS-4 CPU-side bus sequencer: runs the 8-phase instruction cycle, serializes
// fetch addresses onto the 4-bit bus and collects instruction / I/O read data.
package mcs4;
  typedef logic [3:0] char_t;
  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;
endpackage

module mcs4_bus_master #(
  parameter int unsigned CL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        sync,
  output logic        cm_rom,
  output logic        cl_rom,
  output logic [3:0]  dbus_out,
  input  logic [3:0]  dbus_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic        req_io,
  input  logic        req_src,
  input  logic        req_drive,
  input  logic [7:0]  req_xdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_instr,
  output logic [3:0]  rsp_rd
);
  import mcs4::*;

  localparam int CW = $clog2(CL_CYCLES + 1);

  instr_cyc_t  r_phase, w_phase_nxt;
  logic [CW-1:0] r_cl_cnt;
  logic        r_active;
  logic [11:0] r_addr;
  logic        r_io, r_src, r_drive;
  logic [7:0]  r_xdata;
  logic [7:0]  r_instr;
  logic [3:0]  r_rd;
  logic        w_cl, w_accept;
  char_t       w_dbus;
  logic        w_cm;

  assign w_cl      = (r_cl_cnt != '0);
  assign req_ready = (r_phase == X3) && !rst && !w_cl;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= X3;
      r_cl_cnt <= CW'(CL_CYCLES);
      r_active <= 1'b0;
      r_addr   <= '0;
      r_io     <= 1'b0;
      r_src    <= 1'b0;
      r_drive  <= 1'b0;
      r_xdata  <= '0;
      r_instr  <= '0;
      r_rd     <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      if (w_cl) r_cl_cnt <= r_cl_cnt - 1'b1;
      // Request fields are frozen at the X3 boundary and hold for the whole cycle.
      if (r_phase == X3) begin
        r_active <= w_accept;
        if (w_accept) begin
          r_addr  <= req_addr;
          r_io    <= req_io;
          r_src   <= req_src;
          r_drive <= req_drive;
          r_xdata <= req_xdata;
        end
      end
      if (r_active) begin
        case (r_phase)
          M1:      r_instr[7:4] <= dbus_in;
          M2:      r_instr[3:0] <= dbus_in;
          X2:      r_rd         <= dbus_in;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_phase_nxt = instr_cyc_t'(r_phase + 3'd1);
    w_dbus      = '0;
    w_cm        = 1'b0;
    if (r_active) begin
      case (r_phase)
        A1: w_dbus = r_addr[3:0];
        A2: w_dbus = r_addr[7:4];
        A3: w_dbus = r_addr[11:8];
        M2: w_cm   = r_io;
        X2: begin
          w_dbus = r_drive ? r_xdata[7:4] : 4'h0;
          w_cm   = r_src;
        end
        X3: begin
          w_dbus = r_drive ? r_xdata[3:0] : 4'h0;
          w_cm   = r_src;
        end
        default: ;
      endcase
    end
  end

  assign sync      = (r_phase == X3);
  assign cl_rom    = w_cl;
  assign dbus_out  = w_dbus;
  assign cm_rom    = w_cm;
  assign rsp_valid = r_active && (r_phase == X3) && !rst;
  assign rsp_instr = r_instr;
  assign rsp_rd    = r_rd;
endmodule

// File: doc/mcs4_bus_master.md
Name: mcs4_bus_master

Overview:
- CPU-side bus sequencer: the stage directly upstream of the i4001 ROMs on the MCS-4 4-bit data bus.
- Free-runs the 8-phase instruction cycle and generates sync, cm_rom and cl_rom.
- Serializes a 12-bit fetch address onto dbus_out and assembles the returned 8-bit instruction.
- Also runs the I/O side of each cycle (cm_rom at M2/X2, driving or capturing the X2/X3 nibbles); the CPU core drives it through a valid/ready request port and gets one response per cycle.

Parameters:
- CL_CYCLES, 8: clock cycles cl_rom stays high after rst deasserts (must be ≥1).

Ports:
- clk  in  1  system clock; one clock = one instruction phase.
- rst  in  1  synchronous, active-high reset.
- sync  out  1  high during phase X3; marks cycle boundary for ROM/RAM.
- cm_rom  out  1  ROM command line.
- cl_rom  out  1  ROM I/O clear.
- dbus_out  out  4  mcs4::char_t, bus value driven by this block.
- dbus_in  in  4  mcs4::char_t, wired-OR of all chip outputs.
- req_valid  in  1  request for the next instruction cycle.
- req_ready  out  1  request accepted this clock.
- req_addr  in  12  fetch address.
- req_io  in  1  assert cm_rom in M2 (I/O instruction).
- req_src  in  1  assert cm_rom in X2 (SRC).
- req_drive  in  1  drive req_xdata in X2/X3.
- req_xdata  in  8  [7:4] driven in X2, [3:0] in X3.
- rsp_valid  out  1  one-clock pulse, cycle complete.
- rsp_instr  out  8  fetched byte, OPR in [7:4], OPA in [3:0].
- rsp_rd  out  4  dbus_in sampled in X2.

Behaviour:
- Phase counter, 3 bits, mcs4::instr_cyc_t encoding: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
  - Increments every clock and wraps X3→A1.
  - sync = (phase==X3), combinational from the phase register.
  - Resulting alignment: a ROM reset by sync sits in A1 exactly when this block does.
- Reset (rst=1):
  - phase←X3, so sync=1 during reset and the first post-reset clock, and the first full cycle starts at A1 after it.
  - Active/latched request cleared.
  - cl_rom=1, dbus_out=0, cm_rom=0, req_ready=0, rsp_valid=0, rsp_instr=0, rsp_rd=0.
  - Reset mid-cycle abandons the cycle; no response is issued.
- cl_rom:
  - Down-counter loaded with CL_CYCLES while rst is high.
  - cl_rom=1 while the counter is nonzero; decrements each clock after rst falls.
- Acceptance:
  - req_ready=1 only when phase==X3 and rst==0 and cl_rom==0.
  - On req_valid&&req_ready the request is latched and the next A1..X3 is an active cycle.
  - Otherwise the next cycle is a bubble: dbus_out=0 and cm_rom=0 throughout, no response.
  - Back-to-back requests give zero-gap cycles (one request per 8 clocks).
- Active cycle, dbus_out:
  - A1 = addr[3:0], A2 = addr[7:4], A3 = addr[11:8].
  - X2 = xdata[7:4] if drive, else 0.
  - X3 = xdata[3:0] if drive, else 0.
  - M1, M2, X1 = 0.
- Active cycle, cm_rom: 1 in M2 if req_io; 1 in X2 and X3 if req_src; else 0.
- Captures:
  - rsp_instr[7:4] ← dbus_in at end of M1.
  - rsp_instr[3:0] ← dbus_in at end of M2.
  - rsp_rd ← dbus_in at end of X2.
  - rsp_instr and rsp_rd hold until the next capture.
- rsp_valid:
  - Asserted during X3 of an active cycle; coincides with req_ready for the next request.
  - Latency is 7 clocks from A1.
  - rsp_instr and rsp_rd are stable during the pulse.
- Simultaneous req_io and req_src are both honoured. req_drive with req_src drives the SRC pair: X2 = high nibble, X3 = low nibble.
- req_* are sampled only on acceptance; later changes do not affect the running cycle.
- dbus_in is ignored in bubble cycles and in phases other than M1/M2/X2.

Test Plan:
- Reset: rst high 3 clocks, CL_CYCLES=8 → sync=1, cl_rom=1, dbus_out=0; cl_rom falls 8 clocks after rst falls; first req_ready at the next X3.
- Fetch: addr=0x123, ROM model returns 0xD5 → dbus_out 3,2,1 in A1–A3; sync only in X3; rsp_valid in X3 with rsp_instr=0xD5.
- Back-to-back fetches: 0x000, 0x0FF, 0xFFF with req_valid always high → three responses exactly 8 clocks apart; no bubble.
- Bubble: req_valid low at one X3 → next cycle dbus_out=0, cm_rom=0, no rsp_valid; sync period stays 8.
- I/O: req_io=1, req_drive=1, xdata=0xA0 → cm_rom=1 only in M2; dbus_out=0xA in X2. With dbus_in=0x6 in X2 → rsp_rd=0x6.
- SRC: req_src=1, req_drive=1, xdata=0x5C → cm_rom=1 in X2 and X3, dbus_out 5 then C. Reset asserted at M1 of the next cycle → no rsp_valid, outputs at reset values.
